// File: rtl/range_hood_pkg.sv
// Shared types and constants for the range-hood key front end and mode FSM.
package range_hood_pkg;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HELD,
    P_LONG
  } power_state_t;

  localparam int unsigned EV_LONG    = 0;
  localparam int unsigned EV_SHORT   = 1;
  localparam int unsigned EV_LEVEL1  = 2;
  localparam int unsigned EV_LEVEL2  = 3;
  localparam int unsigned EV_LEVEL3  = 4;
  localparam int unsigned EV_CLEAN   = 5;
  localparam int unsigned NUM_EVENTS = 6;

  localparam int unsigned KEY_POWER  = 0;
  localparam int unsigned NUM_KEYS   = 5;

  typedef enum logic [2:0] {
    HOOD_OFF,
    HOOD_STANDBY,
    HOOD_LEVEL1,
    HOOD_LEVEL2,
    HOOD_LEVEL3,
    HOOD_CLEAN
  } hood_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stable-sample debounce counter for one raw button.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // this is the DEBOUNCE_CYCLES-th consecutive differing sample
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
        fall  <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_press_scheduler.sv
// Debounces the five panel keys, classifies power short/long presses and
// issues at most one prioritised single-cycle event pulse per clock.
module key_press_scheduler
  import range_hood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 300_000_000,
  parameter int unsigned CNT_W             = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_power,
  input  logic       btn_level1,
  input  logic       btn_level2,
  input  logic       btn_level3,
  input  logic       btn_clean,
  output logic       power_menu_short_press,
  output logic       power_menu_long_press,
  output logic       first_level_press,
  output logic       second_level_press,
  output logic       third_level_press,
  output logic       self_clean_press,
  output logic [4:0] keys_level,
  output logic       event_drop
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES);

  logic [NUM_KEYS-1:0]   raw;
  logic [NUM_KEYS-1:0]   key_rise;
  logic [NUM_KEYS-1:0]   key_fall;
  logic                  unused_fall;

  power_state_t          p_state, p_next;
  logic [CNT_W-1:0]      hold_cnt, hold_next;
  logic                  set_long, set_short;

  logic [NUM_EVENTS-1:0] pending, pending_next;
  logic [NUM_EVENTS-1:0] set_vec, grant, grant_q;
  logic                  drop_next;

  assign raw = {btn_clean, btn_level3, btn_level2, btn_level1, btn_power};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (raw[i]),
      .level(keys_level[i]),
      .rise (key_rise[i]),
      .fall (key_fall[i])
    );
  end

  // Release is tracked through the debounced level so a fall coinciding
  // with the long-press decision cannot be lost.
  assign unused_fall = ^key_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state  <= P_IDLE;
      hold_cnt <= '0;
    end else begin
      p_state  <= p_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    p_next    = p_state;
    hold_next = hold_cnt;
    set_long  = 1'b0;
    set_short = 1'b0;
    unique case (p_state)
      P_IDLE: begin
        if (key_rise[KEY_POWER]) begin
          p_next    = P_HELD;
          hold_next = '0;
        end
      end
      P_HELD: begin
        if (hold_cnt == LONG_LAST) begin
          set_long = 1'b1;
          p_next   = P_LONG;
        end else if (!keys_level[KEY_POWER]) begin
          set_short = 1'b1;
          p_next    = P_IDLE;
        end else begin
          hold_next = hold_cnt + CNT_W'(1);
        end
      end
      P_LONG: begin
        if (!keys_level[KEY_POWER]) p_next = P_IDLE;
      end
      default: p_next = P_IDLE;
    endcase
  end

  // Lowest set bit wins, which is exactly LONG > SHORT > L1 > L2 > L3 > CLEAN.
  assign grant   = pending & (~pending + NUM_EVENTS'(1));
  assign set_vec = {key_rise[NUM_KEYS-1:1], set_short, set_long};

  always_comb begin
    pending_next = (pending & ~grant) | set_vec;
    drop_next    = |(set_vec & pending & ~grant);
    if (set_long) pending_next[EV_CLEAN:EV_LEVEL1] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      grant_q    <= '0;
      event_drop <= 1'b0;
    end else begin
      pending    <= pending_next;
      grant_q    <= grant;
      event_drop <= drop_next;
    end
  end

  assign power_menu_long_press  = grant_q[EV_LONG];
  assign power_menu_short_press = grant_q[EV_SHORT];
  assign first_level_press      = grant_q[EV_LEVEL1];
  assign second_level_press     = grant_q[EV_LEVEL2];
  assign third_level_press      = grant_q[EV_LEVEL3];
  assign self_clean_press       = grant_q[EV_CLEAN];

endmodule

// File: tb/tb_key_press_scheduler.sv
// Scoreboard bench for key_press_scheduler: directed scenarios plus random key activity.
module tb_key_press_scheduler;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_vec;
  logic       power_menu_short_press, power_menu_long_press;
  logic       first_level_press, second_level_press, third_level_press, self_clean_press;
  logic [4:0] keys_level;
  logic       event_drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_press_scheduler #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LNG),
    .CNT_W            (32)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .btn_power             (btn_vec[0]),
    .btn_level1            (btn_vec[1]),
    .btn_level2            (btn_vec[2]),
    .btn_level3            (btn_vec[3]),
    .btn_clean             (btn_vec[4]),
    .power_menu_short_press(power_menu_short_press),
    .power_menu_long_press (power_menu_long_press),
    .first_level_press     (first_level_press),
    .second_level_press    (second_level_press),
    .third_level_press     (third_level_press),
    .self_clean_press      (self_clean_press),
    .keys_level            (keys_level),
    .event_drop            (event_drop)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        drop;
    logic [5:0]  ev;   // bit order: long, short, l1, l2, l3, clean
  } exp_t;
  exp_t exp_q[$];

  // Reference model: keys are judged on their sample history, power on how
  // long it has been held, and events queue in a priority-ordered bit array.
  logic [4:0]  m_s1 = '0, m_s2 = '0, m_lev = '0, m_rise = '0;
  int unsigned m_run[5];
  bit          m_held = 0, m_long = 0;
  int unsigned m_hold = 0;
  bit [5:0]    m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    bit [5:0] g, s;
    bit       d;
    logic     samp;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lev = '0; m_rise = '0;
      for (int k = 0; k < 5; k++) m_run[k] = 0;
      m_held = 0; m_long = 0; m_hold = 0; m_pend = '0;
      exp_q.delete();
    end else begin
      g = '0;
      for (int i = 0; i < 6; i++) if (m_pend[i]) begin g[i] = 1'b1; break; end
      s = '0;
      for (int k = 1; k < 5; k++) if (m_rise[k]) s[k+1] = 1'b1;
      if (!m_held) begin
        if (m_rise[0]) begin m_held = 1; m_long = 0; m_hold = 0; end
      end else if (m_long) begin
        if (!m_lev[0]) m_held = 0;
      end else if (m_hold == LNG) begin
        s[0] = 1'b1; m_long = 1;
      end else if (!m_lev[0]) begin
        s[1] = 1'b1; m_held = 0;
      end else begin
        m_hold++;
      end
      d      = |(s & m_pend & ~g);
      m_pend = (m_pend & ~g) | s;
      if (s[0]) m_pend[5:2] = '0;
      if (g != '0 || d) exp_q.push_back('{cyc + 1, d, g});
      for (int k = 0; k < 5; k++) begin
        samp      = m_s2[k];
        m_rise[k] = 1'b0;
        if (samp != m_lev[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_lev[k]  = samp;
            m_run[k]  = 0;
            m_rise[k] = samp;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_vec;
    end
  end

  int          ev_cnt[6];
  int unsigned l1_last_cyc = 0;

  always @(negedge clk) begin
    logic [5:0] dut_ev;
    exp_t       e;
    dut_ev = {self_clean_press, third_level_press, second_level_press,
              first_level_press, power_menu_short_press, power_menu_long_press};
    if (!rst_n) begin
      checks++;
      if (dut_ev != '0 || event_drop || keys_level != '0) begin
        failures++;
        $display("FAIL reset_state: ev=%b drop=%b keys=%b required all zero", dut_ev, event_drop, keys_level);
      end
    end else begin
      for (int i = 0; i < 6; i++) if (dut_ev[i]) ev_cnt[i]++;
      if (first_level_press) l1_last_cyc = cyc;
      checks++;
      if ($countones(dut_ev) > 1) begin
        failures++;
        $display("FAIL onehot: cyc=%0d ev=%b required at most one bit", cyc, dut_ev);
      end
      checks++;
      if (keys_level != m_lev) begin
        failures++;
        $display("FAIL keys_level: cyc=%0d got=%b required=%b", cyc, keys_level, m_lev);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missing_event: cyc=%0d got nothing required ev=%b drop=%b", e.cyc, e.ev, e.drop);
      end
      if (dut_ev != '0 || event_drop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: cyc=%0d got ev=%b drop=%b required none", cyc, dut_ev, event_drop);
        end else begin
          e = exp_q.pop_front();
          if (e.ev != dut_ev || e.drop != event_drop || e.cyc != cyc) begin
            failures++;
            $display("FAIL event: got cyc=%0d ev=%b drop=%b required cyc=%0d ev=%b drop=%b",
                     cyc, dut_ev, event_drop, e.cyc, e.ev, e.drop);
          end
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) ev_cnt[i] = 0;
  endtask

  task automatic expect_count(input string name, input int idx, input int req);
    checks++;
    if (ev_cnt[idx] != req) begin
      failures++;
      $display("FAIL %s: got=%0d required=%0d", name, ev_cnt[idx], req);
    end
  endtask

  initial begin
    int unsigned t0;
    int unsigned left[5];
    rst_n   = 1'b0;
    btn_vec = '0;
    clear_counts();
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1: level1 press, fixed latency, nothing on release
    clear_counts();
    t0 = cyc;
    btn_vec[1] = 1'b1; tick(10);
    btn_vec[1] = 1'b0; tick(20);
    expect_count("t1_l1_count", 2, 1);
    checks++;
    if (l1_last_cyc != t0 + DEB + 4) begin
      failures++;
      $display("FAIL t1_latency: got=%0d required=%0d", l1_last_cyc, t0 + DEB + 4);
    end

    // 2: power bouncing faster than the debounce window
    clear_counts();
    for (int i = 0; i < 8; i++) begin btn_vec[0] = ~btn_vec[0]; tick(2); end
    btn_vec[0] = 1'b0; tick(20);
    expect_count("t2_short", 1, 0);
    expect_count("t2_long", 0, 0);

    // 3: short power press
    clear_counts();
    btn_vec[0] = 1'b1; tick(12);
    btn_vec[0] = 1'b0; tick(30);
    expect_count("t3_short", 1, 1);
    expect_count("t3_long", 0, 0);

    // 4: long power hold with level2 pressed shortly after power debounces
    clear_counts();
    btn_vec[0] = 1'b1; tick(DEB + 4);
    btn_vec[2] = 1'b1; tick(10);
    btn_vec[2] = 1'b0; tick(40 - DEB - 14);
    btn_vec[0] = 1'b0; tick(30);
    expect_count("t4_long", 0, 1);
    expect_count("t4_short", 1, 0);

    // 5: three keys on the same edge
    clear_counts();
    btn_vec[1] = 1'b1; btn_vec[2] = 1'b1; btn_vec[4] = 1'b1; tick(12);
    btn_vec = '0; tick(20);
    expect_count("t5_l1", 2, 1);
    expect_count("t5_l2", 3, 1);
    expect_count("t5_clean", 5, 1);

    // 6: level3 pressed twice amid competing keys
    clear_counts();
    btn_vec[0] = 1'b1; btn_vec[3] = 1'b1; btn_vec[1] = 1'b1;
    tick(DEB); btn_vec[0] = 1'b0; btn_vec[3] = 1'b0; btn_vec[1] = 1'b0;
    tick(DEB); btn_vec[3] = 1'b1; btn_vec[2] = 1'b1;
    tick(DEB + 2); btn_vec = '0; tick(30);

    // 7: reset during a power hold
    clear_counts();
    btn_vec[0] = 1'b1; tick(DEB + 4 + 15);
    rst_n = 1'b0; tick(1);
    btn_vec[0] = 1'b0; tick(2);
    rst_n = 1'b1; tick(40);
    expect_count("t7_long", 0, 0);
    expect_count("t7_short", 1, 0);

    // random activity with occasional bounce bursts and resets
    for (int k = 0; k < 5; k++) left[k] = $urandom_range(1, 10);
    repeat (4000) begin
      for (int k = 0; k < 5; k++) begin
        if (left[k] == 0) begin
          btn_vec[k] = ~btn_vec[k];
          if ($urandom_range(0, 3) == 0) left[k] = $urandom_range(1, 3);
          else left[k] = (k == 0) ? $urandom_range(4, 45) : $urandom_range(4, 25);
        end else begin
          left[k]--;
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      tick(1);
    end
    btn_vec = '0;
    tick(60);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d events outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
